quant_tile_arb: RTL and testbench
=================================

QUANT_TILE_ARB -- requirements
Module: quant_tile_arb

Interface
REQ-001 SHALL have parameter LANES_NUM, default 16: elements per beat.
REQ-002 SHALL have parameter FP_DATA_W, default 32: element width.
REQ-003 SHALL have parameter MAT_SIZE, default 16: tile edge, so the tile holds MAT_SIZE*MAT_SIZE elements.
REQ-004 SHALL have parameters FP_EXP_W 8 and FP_MANT_W 23: widths of the per-row scale fields.
REQ-005 SHALL define IN_BEATS = MAT_SIZE*MAT_SIZE/LANES_NUM, which is 16 at the defaults.
REQ-006 clk  in  1  single clock; every register is rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 rK_s_valid_i / rK_s_ready_o  in/out  1 each, K=0,1  per-requester tile input handshake.
REQ-009 rK_s_data_i  in  LANES_NUM*FP_DATA_W, K=0,1  requester tile beat.
REQ-010 rK_scl_valid_o / rK_scl_ready_i  out/in  1 each, K=0,1  per-requester scale handshake.
REQ-011 rK_m_valid_o / rK_m_ready_i  out/in  1 each, K=0,1  per-requester quantized-output handshake.
REQ-012 scl_mant_o  out  FP_MANT_W*MAT_SIZE  and  scl_exp_o  out  FP_EXP_W*MAT_SIZE  shared scale bus, driven to both requesters.
REQ-013 m_data_o  out  LANES_NUM*FP_DATA_W  shared quantized beat, driven to both requesters.
REQ-014 q_s_valid_o / q_s_ready_i / q_s_data_o  out/in/out  1/1/LANES_NUM*FP_DATA_W  engine input stream.
REQ-015 q_scl_valid_i / q_scl_ready_o / q_mant_i / q_exp_i  in/out/in/in  engine scale port, with scale widths as in REQ-012.
REQ-016 q_m_valid_i / q_m_ready_o / q_m_data_i  in/out/in  engine output stream.
REQ-017 owner_o  out  1  requester that holds the current grant.
REQ-018 busy_o  out  1  high whenever state is not IDLE.
REQ-019 tile_done_o  out  1  one-cycle pulse when a tile completes.
REQ-020 err_o  out  1  sticky protocol-error flag.

Function
REQ-021 SHALL share one row-scaled quantize engine between two requesters, with the grant held for a whole tile: FILL, then SCALE, then EMIT.
REQ-022 The FSM SHALL have states IDLE, FILL, SCALE and EMIT.
REQ-023 IDLE: if any rK_s_valid_i is high, the FSM SHALL latch owner and go to FILL on the next edge; no beat is accepted in IDLE (1-cycle arbitration bubble).
REQ-024 Arbitration SHALL be round-robin: if both are valid, grant the requester other than last_grant; if one is valid, grant it.
REQ-025 FILL routing SHALL be combinational and zero-latency: q_s_valid_o = r[owner]_s_valid_i; q_s_data_o = r[owner]_s_data_i; r[owner]_s_ready_o = q_s_ready_i.
REQ-026 The non-owner's s_ready_o SHALL be 0, and every rK_s_ready_o SHALL be 0 outside FILL.
REQ-027 in_cnt SHALL count q_s fires; the fire with in_cnt == IN_BEATS-1 SHALL move the FSM to SCALE and clear in_cnt.
REQ-028 SCALE: r[owner]_scl_valid_o = q_scl_valid_i; q_scl_ready_o = r[owner]_scl_ready_i; scl_mant_o/scl_exp_o = q_mant_i/q_exp_i (combinational).
REQ-029 A scale fire SHALL move the FSM to EMIT.
REQ-030 EMIT: r[owner]_m_valid_o = q_m_valid_i; q_m_ready_o = r[owner]_m_ready_i; m_data_o = q_m_data_i.
REQ-031 out_cnt SHALL count m fires; the fire with out_cnt == IN_BEATS-1 SHALL go to IDLE, clear out_cnt, set last_grant <= owner, and pulse tile_done_o for 1 cycle.
REQ-032 The non-owner's scl_valid_o and m_valid_o SHALL be 0 at all times, and each port's valid/ready SHALL be 0 outside its own state.
REQ-033 Shared buses SHALL carry the engine value only in their own state and 0 otherwise.
REQ-034 Back-pressure SHALL stall the counters with no beat loss; valid and data SHALL pass through unmodified.
REQ-035 err_o SHALL set if q_scl_valid_i is high outside SCALE or q_m_valid_i is high outside EMIT; it SHALL clear only on rst.
REQ-036 A request from the non-owner during a tile SHALL be held off (ready 0) and served in the IDLE that follows.
REQ-037 When the last EMIT fire and a new request coincide, the FSM SHALL take the IDLE cycle first; it SHALL NOT go directly to FILL.
REQ-038 Counters SHALL be clog2(IN_BEATS) bits wide and SHALL never exceed IN_BEATS-1.

Reset
REQ-039 While rst is high the block SHALL hold: state IDLE, owner_o 0, last_grant 1 (requester 0 wins first), in_cnt 0, out_cnt 0, tile_done_o 0, err_o 0.
REQ-040 Every valid, ready and shared bus SHALL be 0 during reset.
REQ-041 rst asserted mid-tile SHALL abort the tile with no completion pulse; the engine SHALL be reset by the same rst.

Verification
REQ-042 Both requesters valid out of reset -> r0 granted (owner_o=0), 16 beats, scale, 16 out beats, tile_done_o; then r1 granted with no r0 beats accepted.
REQ-043 Only r1 requesting across 3 tiles -> r1 granted each time; exactly 1 idle cycle between tiles; tile_done_o pulses 3 times.
REQ-044 Random stalls on q_s_ready_i, rK_scl_ready_i and rK_m_ready_i -> all 256 elements and the scale are delivered in order, with no duplication.
REQ-045 q_m_valid_i forced high during FILL -> err_o=1 and stays 1 until rst.
REQ-046 rst asserted at beat 7 of EMIT -> next cycle busy_o=0 and all outputs 0; the next tile starts with r0 priority.

Source files
------------

// File: rtl/quant_tile_arb.sv
// quant_tile_arb
// Shares one row-scaled quantize engine between two requesters. The grant is
// held for a whole tile: FILL streams IN_BEATS input beats into the engine,
// SCALE forwards the per-row scale vector back to the owner, and EMIT
// streams IN_BEATS quantized beats back to the owner. Arbitration is
// round-robin and happens only in IDLE, which costs one bubble cycle per tile.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   rK_s_valid_i/_ready_o/_data_i requester K tile input stream (K = 0,1)
//   rK_scl_valid_o/_ready_i       requester K scale handshake
//   rK_m_valid_o/_ready_i         requester K quantized-output handshake
//   scl_mant_o, scl_exp_o         shared scale bus (valid only in SCALE)
//   m_data_o                      shared quantized beat (valid only in EMIT)
//   q_s_*                         engine input stream
//   q_scl_*, q_mant_i, q_exp_i    engine scale port
//   q_m_*                         engine output stream
//   owner_o                       requester holding the current grant
//   busy_o                        high whenever the FSM is not IDLE
//   tile_done_o                   one-cycle pulse after a tile completes
//   err_o                         sticky protocol-error flag
module quant_tile_arb #(
  parameter int LANES_NUM = 16,
  parameter int FP_DATA_W = 32,
  parameter int MAT_SIZE  = 16,
  parameter int FP_EXP_W  = 8,
  parameter int FP_MANT_W = 23
) (
  input  logic                              clk,
  input  logic                              rst,
  // requester 0
  input  logic                              r0_s_valid_i,
  output logic                              r0_s_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0]    r0_s_data_i,
  output logic                              r0_scl_valid_o,
  input  logic                              r0_scl_ready_i,
  output logic                              r0_m_valid_o,
  input  logic                              r0_m_ready_i,
  // requester 1
  input  logic                              r1_s_valid_i,
  output logic                              r1_s_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0]    r1_s_data_i,
  output logic                              r1_scl_valid_o,
  input  logic                              r1_scl_ready_i,
  output logic                              r1_m_valid_o,
  input  logic                              r1_m_ready_i,
  // shared requester-side buses
  output logic [FP_MANT_W*MAT_SIZE-1:0]     scl_mant_o,
  output logic [FP_EXP_W*MAT_SIZE-1:0]      scl_exp_o,
  output logic [LANES_NUM*FP_DATA_W-1:0]    m_data_o,
  // engine side
  output logic                              q_s_valid_o,
  input  logic                              q_s_ready_i,
  output logic [LANES_NUM*FP_DATA_W-1:0]    q_s_data_o,
  input  logic                              q_scl_valid_i,
  output logic                              q_scl_ready_o,
  input  logic [FP_MANT_W*MAT_SIZE-1:0]     q_mant_i,
  input  logic [FP_EXP_W*MAT_SIZE-1:0]      q_exp_i,
  input  logic                              q_m_valid_i,
  output logic                              q_m_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0]    q_m_data_i,
  // status
  output logic                              owner_o,
  output logic                              busy_o,
  output logic                              tile_done_o,
  output logic                              err_o
);

  localparam int IN_BEATS = MAT_SIZE * MAT_SIZE / LANES_NUM;
  // A one-beat tile would make $clog2 return 0; keep at least one bit.
  localparam int CNT_W = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             tile_done_q, tile_done_d;
  logic             err_q, err_d;

  logic s_fire, scl_fire, m_fire;
  logic any_req, grant;

  // Datapath routing. Every handshake and shared bus is forced to zero unless
  // the FSM is in the state that owns it, and only the owner's side is
  // connected; the non-owner sees zero valid/ready at all times.
  always_comb begin
    r0_s_ready_o   = 1'b0;
    r1_s_ready_o   = 1'b0;
    r0_scl_valid_o = 1'b0;
    r1_scl_valid_o = 1'b0;
    r0_m_valid_o   = 1'b0;
    r1_m_valid_o   = 1'b0;
    scl_mant_o     = '0;
    scl_exp_o      = '0;
    m_data_o       = '0;
    q_s_valid_o    = 1'b0;
    q_s_data_o     = '0;
    q_scl_ready_o  = 1'b0;
    q_m_ready_o    = 1'b0;
    case (state_q)
      FILL: begin
        if (owner_q) begin
          q_s_valid_o  = r1_s_valid_i;
          q_s_data_o   = r1_s_data_i;
          r1_s_ready_o = q_s_ready_i;
        end else begin
          q_s_valid_o  = r0_s_valid_i;
          q_s_data_o   = r0_s_data_i;
          r0_s_ready_o = q_s_ready_i;
        end
      end
      SCALE: begin
        scl_mant_o = q_mant_i;
        scl_exp_o  = q_exp_i;
        if (owner_q) begin
          r1_scl_valid_o = q_scl_valid_i;
          q_scl_ready_o  = r1_scl_ready_i;
        end else begin
          r0_scl_valid_o = q_scl_valid_i;
          q_scl_ready_o  = r0_scl_ready_i;
        end
      end
      EMIT: begin
        m_data_o = q_m_data_i;
        if (owner_q) begin
          r1_m_valid_o = q_m_valid_i;
          q_m_ready_o  = r1_m_ready_i;
        end else begin
          r0_m_valid_o = q_m_valid_i;
          q_m_ready_o  = r0_m_ready_i;
        end
      end
      default: ;
    endcase
  end

  // The routed handshakes are already zero outside their own state, so a
  // fire can only happen in the matching state.
  assign s_fire   = q_s_valid_o & q_s_ready_i;
  assign scl_fire = q_scl_valid_i & q_scl_ready_o;
  assign m_fire   = q_m_valid_i & q_m_ready_o;

  // Round-robin: with both requesting, the one that did not finish the last
  // tile wins; otherwise the single requester wins.
  assign any_req = r0_s_valid_i | r1_s_valid_i;
  assign grant   = (r0_s_valid_i & r1_s_valid_i) ? ~last_grant_q : r1_s_valid_i;

  // Next-state logic. Completing a tile always returns to IDLE first, even if
  // a request is already pending, so each tile pays exactly one bubble.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    tile_done_d  = 1'b0;
    err_d        = err_q;
    if ((q_scl_valid_i && state_q != SCALE) || (q_m_valid_i && state_q != EMIT)) begin
      err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant;
          state_d = FILL;
        end
      end
      FILL: begin
        if (s_fire) begin
          if (in_cnt_q == LAST_BEAT) begin
            in_cnt_d = '0;
            state_d  = SCALE;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      SCALE: begin
        if (scl_fire) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (m_fire) begin
          if (out_cnt_q == LAST_BEAT) begin
            out_cnt_d    = '0;
            state_d      = IDLE;
            last_grant_d = owner_q;
            tile_done_d  = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. last_grant resets to 1 so requester 0 wins the first
  // contested arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      tile_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      tile_done_q  <= tile_done_d;
      err_q        <= err_d;
    end
  end

  assign owner_o     = owner_q;
  assign busy_o      = (state_q != IDLE);
  assign tile_done_o = tile_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_quant_tile_arb.sv
// Directed bench for quant_tile_arb at default parameters. The bench plays
// both requesters and the engine; expected data is generated from the beat
// index so any loss, duplication or reordering shows up as a data miss.
module tb_quant_tile_arb;

   localparam int LANES   = 16;
   localparam int DWORD   = 32;
   localparam int MAT     = 16;
   localparam int EXPW    = 8;
   localparam int MANTW   = 23;
   localparam int DW      = LANES * DWORD;
   localparam int NBEATS  = MAT * MAT / LANES;
   localparam int CW      = 512;

   logic clk = 1'b0;
   logic rst;
   logic r0_s_valid_i, r0_s_ready_o, r0_scl_valid_o, r0_scl_ready_i, r0_m_valid_o, r0_m_ready_i;
   logic r1_s_valid_i, r1_s_ready_o, r1_scl_valid_o, r1_scl_ready_i, r1_m_valid_o, r1_m_ready_i;
   logic [DW-1:0] r0_s_data_i, r1_s_data_i, m_data_o, q_s_data_o, q_m_data_i;
   logic [MANTW*MAT-1:0] scl_mant_o, q_mant_i;
   logic [EXPW*MAT-1:0] scl_exp_o, q_exp_i;
   logic q_s_valid_o, q_s_ready_i, q_scl_valid_i, q_scl_ready_o, q_m_valid_i, q_m_ready_o;
   logic owner_o, busy_o, tile_done_o, err_o;

   int checks = 0;
   int errors = 0;
   bit lastGrantExp;
   bit errExp;
   bit doneExp;

   quant_tile_arb dut (
      .clk(clk), .rst(rst),
      .r0_s_valid_i(r0_s_valid_i), .r0_s_ready_o(r0_s_ready_o), .r0_s_data_i(r0_s_data_i),
      .r0_scl_valid_o(r0_scl_valid_o), .r0_scl_ready_i(r0_scl_ready_i),
      .r0_m_valid_o(r0_m_valid_o), .r0_m_ready_i(r0_m_ready_i),
      .r1_s_valid_i(r1_s_valid_i), .r1_s_ready_o(r1_s_ready_o), .r1_s_data_i(r1_s_data_i),
      .r1_scl_valid_o(r1_scl_valid_o), .r1_scl_ready_i(r1_scl_ready_i),
      .r1_m_valid_o(r1_m_valid_o), .r1_m_ready_i(r1_m_ready_i),
      .scl_mant_o(scl_mant_o), .scl_exp_o(scl_exp_o), .m_data_o(m_data_o),
      .q_s_valid_o(q_s_valid_o), .q_s_ready_i(q_s_ready_i), .q_s_data_o(q_s_data_o),
      .q_scl_valid_i(q_scl_valid_i), .q_scl_ready_o(q_scl_ready_o),
      .q_mant_i(q_mant_i), .q_exp_i(q_exp_i),
      .q_m_valid_i(q_m_valid_i), .q_m_ready_o(q_m_ready_o), .q_m_data_i(q_m_data_i),
      .owner_o(owner_o), .busy_o(busy_o), .tile_done_o(tile_done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Input beat pattern: owner, beat index and lane are all visible in each word.
   function automatic logic [DW-1:0] mkIn(input int own, input int idx);
      logic [DW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*DWORD +: DWORD] = {8'(160 + own), 8'(idx), 16'(l)};
      return r;
   endfunction

   function automatic logic [DW-1:0] mkOut(input int own, input int idx);
      logic [DW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*DWORD +: DWORD] = {8'(192 + own), 8'(idx), 16'(l * 3 + 1)};
      return r;
   endfunction

   function automatic logic [MANTW*MAT-1:0] mkMant(input int own);
      logic [MANTW*MAT-1:0] r;
      for (int i = 0; i < MAT; i++) r[i*MANTW +: MANTW] = 23'(i * 1000 + own * 7 + 5);
      return r;
   endfunction

   function automatic logic [EXPW*MAT-1:0] mkExp(input int own);
      logic [EXPW*MAT-1:0] r;
      for (int i = 0; i < MAT; i++) r[i*EXPW +: EXPW] = 8'(i + own * 16 + 1);
      return r;
   endfunction

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearEngine();
      q_s_ready_i    = 1'b0;
      q_scl_valid_i  = 1'b0;
      q_mant_i       = '0;
      q_exp_i        = '0;
      q_m_valid_i    = 1'b0;
      q_m_data_i     = '0;
      r0_scl_ready_i = 1'b0;
      r1_scl_ready_i = 1'b0;
      r0_m_ready_i   = 1'b0;
      r1_m_ready_i   = 1'b0;
   endtask

   function automatic bit coin(input int pct);
      return ($urandom_range(0, 99) >= pct);
   endfunction

   // Runs one full tile starting from the IDLE cycle. stallPct throttles
   // valid/ready on every handshake, errAt injects an out-of-state engine
   // m_valid during FILL, abortAt asserts rst after that many EMIT fires.
   task automatic applyStimulus(input bit r0v, input bit r1v, input int stallPct,
                                input int errAt, input int abortAt);
      int  own, idx, cyc;
      bit  v, rdy, fin, aborted;
      own = (r0v && r1v) ? int'(!lastGrantExp) : int'(r1v);
      aborted = 1'b0;

      // IDLE / arbitration bubble
      clearEngine();
      r0_s_valid_i = r0v; r0_s_data_i = mkIn(0, 0);
      r1_s_valid_i = r1v; r1_s_data_i = mkIn(1, 0);
      #1;
      checkOutput("idle_busy", busy_o, 0);
      checkOutput("idle_r0_ready", r0_s_ready_o, 0);
      checkOutput("idle_r1_ready", r1_s_ready_o, 0);
      checkOutput("idle_done", tile_done_o, doneExp);
      checkOutput("idle_err", err_o, errExp);
      nextCycle();
      doneExp = 1'b0;

      // FILL
      idx = 0; cyc = 0;
      while (idx < NBEATS && cyc < 400) begin
         v = coin(stallPct); rdy = coin(stallPct);
         if (own == 1) begin
            r1_s_valid_i = v; r1_s_data_i = mkIn(1, idx);
            r0_s_valid_i = r0v; r0_s_data_i = mkIn(0, 200);
         end else begin
            r0_s_valid_i = v; r0_s_data_i = mkIn(0, idx);
            r1_s_valid_i = r1v; r1_s_data_i = mkIn(1, 200);
         end
         q_s_ready_i = rdy;
         q_m_valid_i = (cyc == errAt);
         #1;
         checkOutput("fill_busy", busy_o, 1);
         checkOutput("fill_owner", owner_o, own[0]);
         checkOutput("fill_q_valid", q_s_valid_o, v);
         if (v) checkOutput("fill_q_data", q_s_data_o, mkIn(own, idx));
         checkOutput("fill_own_ready", own ? r1_s_ready_o : r0_s_ready_o, rdy);
         checkOutput("fill_other_ready", own ? r0_s_ready_o : r1_s_ready_o, 0);
         checkOutput("fill_own_mvalid", own ? r1_m_valid_o : r0_m_valid_o, 0);
         checkOutput("fill_err", err_o, errExp);
         nextCycle();
         if (v && rdy) idx++;
         if (cyc == errAt) errExp = 1'b1;
         cyc++;
      end
      if (idx < NBEATS) checkOutput("fill_timeout", 32'(idx), 32'(NBEATS));
      q_m_valid_i = 1'b0;
      if (own == 1) r1_s_valid_i = 1'b0; else r0_s_valid_i = 1'b0;

      // SCALE
      fin = 1'b0; cyc = 0;
      while (!fin && cyc < 100) begin
         rdy = coin(stallPct);
         q_scl_valid_i = 1'b1; q_mant_i = mkMant(own); q_exp_i = mkExp(own);
         q_s_ready_i = 1'b1;
         r0_scl_ready_i = own ? 1'b1 : rdy;
         r1_scl_ready_i = own ? rdy : 1'b1;
         #1;
         checkOutput("scl_own_valid", own ? r1_scl_valid_o : r0_scl_valid_o, 1);
         checkOutput("scl_other_valid", own ? r0_scl_valid_o : r1_scl_valid_o, 0);
         checkOutput("scl_q_ready", q_scl_ready_o, rdy);
         checkOutput("scl_mant", scl_mant_o, mkMant(own));
         checkOutput("scl_exp", scl_exp_o, mkExp(own));
         checkOutput("scl_s_ready", {r0_s_ready_o, r1_s_ready_o, q_s_valid_o}, 0);
         nextCycle();
         fin = rdy; cyc++;
      end
      if (!fin) checkOutput("scl_timeout", 0, 1);
      clearEngine();

      // EMIT
      idx = 0; cyc = 0;
      while (idx < NBEATS && cyc < 400 && !aborted) begin
         if (abortAt >= 0 && idx == abortAt) begin
            q_m_valid_i = 1'b1; q_m_data_i = mkOut(own, idx);
            r0_m_ready_i = 1'b1; r1_m_ready_i = 1'b1;
            rst = 1'b1;
            #1;
            checkOutput("abort_busy", busy_o, 0);
            checkOutput("abort_mvalid", {r0_m_valid_o, r1_m_valid_o, q_m_ready_o}, 0);
            checkOutput("abort_mdata", m_data_o, 0);
            checkOutput("abort_owner", owner_o, 0);
            checkOutput("abort_err", err_o, 0);
            nextCycle();
            checkOutput("abort_busy_next", busy_o, 0);
            checkOutput("abort_done_next", tile_done_o, 0);
            clearEngine();
            r0_s_valid_i = 1'b0; r1_s_valid_i = 1'b0;
            rst = 1'b0;
            errExp = 1'b0; lastGrantExp = 1'b1;
            nextCycle();
            checkOutput("abort_done_after", tile_done_o, 0);
            aborted = 1'b1;
         end else begin
            v = coin(stallPct); rdy = coin(stallPct);
            q_m_valid_i = v; q_m_data_i = mkOut(own, idx);
            r0_m_ready_i = own ? 1'b1 : rdy;
            r1_m_ready_i = own ? rdy : 1'b1;
            #1;
            checkOutput("emit_own_valid", own ? r1_m_valid_o : r0_m_valid_o, v);
            checkOutput("emit_other_valid", own ? r0_m_valid_o : r1_m_valid_o, 0);
            checkOutput("emit_q_ready", q_m_ready_o, rdy);
            if (v) checkOutput("emit_data", m_data_o, mkOut(own, idx));
            checkOutput("emit_scl_bus", scl_mant_o, 0);
            checkOutput("emit_done", tile_done_o, 0);
            checkOutput("emit_err", err_o, errExp);
            nextCycle();
            if (v && rdy) idx++;
            cyc++;
         end
      end
      if (!aborted) begin
         if (idx < NBEATS) checkOutput("emit_timeout", 32'(idx), 32'(NBEATS));
         clearEngine();
         lastGrantExp = own[0];
         doneExp = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1;
      clearEngine();
      r0_s_valid_i = 1'b1; r0_s_data_i = mkIn(0, 5);
      r1_s_valid_i = 1'b1; r1_s_data_i = mkIn(1, 5);
      q_s_ready_i = 1'b1; q_m_data_i = mkOut(0, 9); q_mant_i = mkMant(0);
      r0_m_ready_i = 1'b1; r0_scl_ready_i = 1'b1;
      repeat (2) nextCycle();
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_owner", owner_o, 0);
      checkOutput("rst_done", tile_done_o, 0);
      checkOutput("rst_err", err_o, 0);
      checkOutput("rst_ready", {r0_s_ready_o, r1_s_ready_o, q_scl_ready_o, q_m_ready_o}, 0);
      checkOutput("rst_valid", {q_s_valid_o, r0_scl_valid_o, r1_scl_valid_o, r0_m_valid_o, r1_m_valid_o}, 0);
      checkOutput("rst_q_data", q_s_data_o, 0);
      checkOutput("rst_m_data", m_data_o, 0);
      checkOutput("rst_scl_mant", scl_mant_o, 0);
      clearEngine();
      r0_s_valid_i = 1'b0; r1_s_valid_i = 1'b0;
      rst = 1'b0;
      lastGrantExp = 1'b1; errExp = 1'b0; doneExp = 1'b0;
      nextCycle();

      $display("[TB] both requesters contend");
      applyStimulus(1'b1, 1'b1, 0, -1, -1);
      applyStimulus(1'b1, 1'b1, 30, -1, -1);
      applyStimulus(1'b1, 1'b1, 30, -1, -1);

      $display("[TB] r1 alone for three tiles");
      applyStimulus(1'b0, 1'b1, 40, -1, -1);
      applyStimulus(1'b0, 1'b1, 40, -1, -1);
      applyStimulus(1'b0, 1'b1, 40, -1, -1);

      $display("[TB] engine m_valid during FILL");
      applyStimulus(1'b1, 1'b0, 20, 3, -1);

      $display("[TB] reset during EMIT");
      applyStimulus(1'b0, 1'b1, 0, -1, 7);
      applyStimulus(1'b1, 1'b1, 20, -1, -1);

      #1;
      checkOutput("final_done", tile_done_o, 1);
      checkOutput("final_busy", busy_o, 0);
      nextCycle();
      checkOutput("final_done_pulse", tile_done_o, 0);
      checkOutput("final_err", err_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
